// File: rtl/phys_reg_freelist_if.sv
// rtl/phys_reg_freelist_if.sv - dispatch/retire/recover bundle of phys_reg_freelist
// FREELIST_ERR_EN adds the sticky fl_err flag to the bundle.
interface phys_reg_freelist_if #(
  parameter int N_WAY    = 2,
  parameter int PR_BITS  = 6,
  parameter int CNT_BITS = 5
);
  logic [N_WAY-1:0]         alloc_req;
  logic [N_WAY*PR_BITS-1:0] pr_freelist;
  logic                     alloc_grant;
  logic                     stall;
  logic [N_WAY-1:0]         free_valid;
  logic [N_WAY*PR_BITS-1:0] free_pr;
  logic [N_WAY-1:0]         retire_alloc;
  logic                     recover;
  logic [CNT_BITS-1:0]      free_count;
`ifdef FREELIST_ERR_EN
  logic                     fl_err;
`endif

  modport master (
    output alloc_req, free_valid, free_pr, retire_alloc, recover,
    input  pr_freelist, alloc_grant, stall, free_count
`ifdef FREELIST_ERR_EN
    , input fl_err
`endif
  );

  modport slave (
    input  alloc_req, free_valid, free_pr, retire_alloc, recover,
    output pr_freelist, alloc_grant, stall, free_count
`ifdef FREELIST_ERR_EN
    , output fl_err
`endif
  );
endinterface

// File: rtl/phys_reg_freelist.sv
// rtl/phys_reg_freelist.sv - circular freelist of physical register tags with mispredict rewind
// FREELIST_ERR_EN adds a sticky fl_err flag for protocol violations.
module phys_reg_freelist #(
  parameter int NUM_PR    = 64,
  parameter int ARCH_REGS = 32,
  parameter int N_WAY     = 2,
  parameter int PR_BITS   = $clog2(NUM_PR),
  parameter int FL_DEPTH  = NUM_PR - ARCH_REGS - 1,
  parameter int CNT_BITS  = $clog2(FL_DEPTH + 1)
) (
  input logic clock,
  input logic reset,
  phys_reg_freelist_if.slave fl
);
  localparam int PTR_BITS = $clog2(FL_DEPTH);
  localparam int W = CNT_BITS + 1;
  localparam logic [W-1:0] DEPTH = W'(FL_DEPTH);

  logic [PR_BITS-1:0]  entries [FL_DEPTH];
  logic [PTR_BITS-1:0] head, tail, head_next, tail_next;
  logic [CNT_BITS-1:0] count, inflight, count_next, inflight_next;

  logic [N_WAY*PR_BITS-1:0] lanes;
  logic [W-1:0]        req_cnt, free_cnt, ret_cnt, granted, inflight_ret, sum;
  logic                grant;
  logic [N_WAY-1:0]    wr_en;
  logic [PTR_BITS-1:0] wr_idx [N_WAY];

  // Pointers wrap by compare so FL_DEPTH need not be a power of two.
  function automatic logic [PTR_BITS-1:0] ptr_add(input logic [PTR_BITS-1:0] p, input logic [W-1:0] n);
    logic [W-1:0] s;
    s = W'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_BITS'(s);
  endfunction

  function automatic logic [PTR_BITS-1:0] ptr_sub(input logic [PTR_BITS-1:0] p, input logic [W-1:0] n);
    logic [W-1:0] s;
    if (W'(p) >= n) s = W'(p) - n;
    else            s = W'(p) + DEPTH - n;
    return PTR_BITS'(s);
  endfunction

`ifdef FREELIST_ERR_EN
  logic err_event, err_q;
`endif

  always_comb begin
    lanes    = '0;
    req_cnt  = '0;
    free_cnt = '0;
    ret_cnt  = '0;
    wr_en    = '0;
`ifdef FREELIST_ERR_EN
    err_event = 1'b0;
`endif
    for (int n = 0; n < N_WAY; n++) begin
      lanes[n*PR_BITS +: PR_BITS] = entries[ptr_add(head, req_cnt)];
      if (fl.alloc_req[n]) req_cnt = req_cnt + W'(1);
      if (fl.retire_alloc[n]) ret_cnt = ret_cnt + W'(1);
    end
    // Frees are packed at tail in lane order; PR0 and overflow lanes are dropped.
    for (int n = 0; n < N_WAY; n++) begin
      wr_idx[n] = ptr_add(tail, free_cnt);
      if (fl.free_valid[n]) begin
        if (fl.free_pr[n*PR_BITS +: PR_BITS] == '0 || W'(count) + free_cnt >= DEPTH) begin
`ifdef FREELIST_ERR_EN
          err_event = 1'b1;
`endif
        end else begin
          wr_en[n] = 1'b1;
          free_cnt = free_cnt + W'(1);
        end
      end
    end

    grant   = !fl.recover && (req_cnt <= W'(count));
    granted = grant ? req_cnt : '0;

    if (W'(inflight) >= ret_cnt) begin
      inflight_ret = W'(inflight) - ret_cnt;
    end else begin
      inflight_ret = '0;
`ifdef FREELIST_ERR_EN
      err_event = 1'b1;
`endif
    end

    tail_next = ptr_add(tail, free_cnt);
    if (fl.recover) begin
      head_next     = ptr_sub(head, inflight_ret);
      sum           = W'(count) + inflight_ret + free_cnt;
      inflight_next = '0;
    end else begin
      head_next     = ptr_add(head, granted);
      sum           = W'(count) - granted + free_cnt;
      inflight_next = CNT_BITS'(inflight_ret + granted);
    end
    count_next = CNT_BITS'(sum);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= CNT_BITS'(FL_DEPTH);
      inflight <= '0;
      for (int i = 0; i < FL_DEPTH; i++) entries[i] <= PR_BITS'(ARCH_REGS + 1 + i);
    end else begin
      head     <= head_next;
      tail     <= tail_next;
      count    <= count_next;
      inflight <= inflight_next;
      for (int n = 0; n < N_WAY; n++)
        if (wr_en[n]) entries[wr_idx[n]] <= fl.free_pr[n*PR_BITS +: PR_BITS];
    end
  end

`ifdef FREELIST_ERR_EN
  always_ff @(posedge clock) begin
    if (reset)          err_q <= 1'b0;
    else if (err_event) err_q <= 1'b1;
  end
  assign fl.fl_err = err_q;
`endif

  assign fl.pr_freelist = lanes;
  assign fl.alloc_grant = grant;
  assign fl.stall       = |fl.alloc_req && !grant && !fl.recover;
  assign fl.free_count  = count;
endmodule
